// File: rtl/board_io_tester.sv
`default_nettype none
// ============================================================================
// Module   : board_io_tester
// Function : Debounced-key controlled test pattern engine for expansion IO
// Revision : 1.0 - initial release
// ============================================================================
module board_io_tester #(
  parameter int N_IO      = 68,
  parameter int STEP_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [3:0]      i_key,
  output logic [N_IO-1:0] o_io,
  output logic [3:0]      o_led,
  output logic [1:0]      o_mode,
  output logic            o_step
);

  localparam int TW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [TW-1:0]   c_TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [DW-1:0]   c_DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [1:0]      c_ALT       = 2'd0;
  localparam logic [1:0]      c_WALK      = 2'd1;
  localparam logic [1:0]      c_COUNT     = 2'd2;
  localparam logic [1:0]      c_ALL       = 2'd3;
  localparam logic [N_IO-1:0] c_ODD_BITS  = N_IO'({(N_IO/2 + 1){2'b10}});

  logic [TW-1:0]   r_tick_cnt;
  logic            r_step;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_db;
  logic [3:0]      r_db_q;
  logic [3:0]      r_ev;
  logic [DW-1:0]   r_db_cnt [4];
  logic [1:0]      r_mode;
  logic            r_run;
  logic            r_hb;
  logic [N_IO-1:0] r_state;
  logic [N_IO-1:0] r_io;
  logic [1:0]      r_mode_q;
  logic [3:0]      r_led;

  logic [1:0]      w_mode_nxt;
  logic            w_clear;
  logic            w_adv;
  logic [N_IO-1:0] w_adv_val;
  logic [N_IO-1:0] w_state_nxt;
  logic [N_IO-1:0] w_io_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
      r_step     <= 1'b0;
    end else begin
      r_step     <= (r_tick_cnt == c_TICK_LAST);
      r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
    end
  end

  // Event fires one cycle after the debounced level falls, off a delayed copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_db_q  <= '1;
      r_ev    <= '0;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_ev    <= r_db_q & ~r_db;
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == c_DB_LAST) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_mode_nxt = r_ev[0] ? r_mode + 2'd1 : r_mode;
    w_clear    = r_ev[0] | r_ev[3];
    w_adv      = (r_run & r_step) | (~r_run & r_ev[2]);
    w_adv_val  = r_state;
    case (r_mode)
      c_WALK:  w_adv_val = {r_state[N_IO-2:0], r_state[N_IO-1]};
      c_COUNT: w_adv_val = r_state + 1'b1;
      default: w_adv_val[0] = ~r_state[0];
    endcase
    // A clear always beats an advance landing in the same cycle.
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = (w_mode_nxt == c_WALK) ? N_IO'(1) : '0;
    end else if (w_adv) begin
      w_state_nxt = w_adv_val;
    end
  end

  always_comb begin
    case (r_mode)
      c_ALT:   w_io_nxt = r_state[0] ? ~c_ODD_BITS : c_ODD_BITS;
      c_ALL:   w_io_nxt = {N_IO{r_state[0]}};
      default: w_io_nxt = r_state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode   <= c_ALT;
      r_run    <= 1'b1;
      r_hb     <= 1'b0;
      r_state  <= '0;
      r_io     <= '0;
      r_mode_q <= '0;
      r_led    <= '0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_state  <= w_state_nxt;
      if (r_ev[1]) r_run <= ~r_run;
      if (r_step)  r_hb  <= ~r_hb;
      r_io     <= w_io_nxt;
      r_mode_q <= r_mode;
      r_led    <= {r_hb, r_run, r_mode};
    end
  end

  assign o_io   = r_io;
  assign o_led  = r_led;
  assign o_mode = r_mode_q;
  assign o_step = r_step;

endmodule
`default_nettype wire

// File: doc/board_io_tester.md
Name: board_io_tester

Overview:
- Parametrised board bring-up pattern engine. Replaces the free-running divider, fixed LED blink and hard-wired alternating expansion-IO assignments in the board test top.
- Debounces the user keys and drives a selectable test pattern onto N_IO expansion pins at a programmable step rate.
- Patterns: alternating, walking-one, binary count, all-toggle. Supports run/freeze, single-step and pattern clear.
- Sits between the board pins (i_key, o_led, expansion IO) and the rest of the test top.

Parameters:
- N_IO, 68, number of expansion IO outputs (≥2).
- STEP_DIV, 50_000_000, i_clk cycles per pattern step (≥2).
- DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a key level change (≥2).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous to i_clk, active-high.
- i_key  in  4  raw keys, active-low, asynchronous. [0]=mode, [1]=run/freeze, [2]=single step, [3]=pattern clear.
- o_io  out  N_IO  registered test pattern.
- o_led  out  4  [1:0]=mode, [2]=run, [3]=heartbeat.
- o_mode  out  2  current mode.
- o_step  out  1  one-cycle step tick.

Behaviour:
- Reset: i_clk only; synchronous, active-high. On reset:
  - all outputs 0;
  - mode=0 (ALT), run=1, state=0, heartbeat=0;
  - tick counter 0;
  - key sync flops and debounced levels 1 (released);
  - debounce counters 0.
  - Reset asserted mid-operation takes effect at the next edge regardless of activity.
- Tick: counter runs 0..STEP_DIV-1 and wraps. o_step=1 for exactly one cycle when the counter equals STEP_DIV-1, i.e. period STEP_DIV. The first pulse is STEP_DIV edges after reset release. heartbeat toggles on every tick, independent of run.
- Debounce, per key:
  - 2-flop synchroniser feeds debounce logic. If synced≠debounced, increment counter; else clear it.
  - When the counter equals DB_CYCLES-1 and the levels still differ, debounced<=synced and the counter clears.
  - Press event = registered one-cycle pulse on debounced 1→0.
  - Counting the first edge that samples i_key low as edge 1, the pulse is high after edge DB_CYCLES+3.
  - Glitches shorter than DB_CYCLES synced cycles produce no event. Release is debounced the same way but generates no event.
- Control, evaluated every cycle in this priority order (highest first):
  1. key0 event: mode<=mode+1 mod 4; state cleared.
  2. key3 event: state cleared, mode kept.
  3. Advance: taken if (run && o_step) || (!run && key2 event).
  - Clear value: state=1 when the resulting mode is WALK, otherwise 0.
  - key1 event toggles run, independently of the above. A key2 event while run=1 is ignored.
  - A clear and an advance in the same cycle: clear wins and the advance is dropped.
- State: N_IO-bit register. Advance per mode:
  - 0 ALT: state[0]^=1.
  - 1 WALK: rotate left by 1 (bit N_IO-1 → bit 0).
  - 2 COUNT: state+1 modulo 2^N_IO (all-ones → 0).
  - 3 ALL: state[0]^=1.
- Output decode, registered, so o_io lags state by one cycle:
  - ALT: even bits = state[0], odd bits = ~state[0].
  - WALK, COUNT: o_io = state.
  - ALL: all bits = state[0].
- o_mode, o_led[1:0] = mode. o_led[2] = run. o_led[3] = heartbeat. All registered, updated the edge after the source changes.
- No other state. Keys held indefinitely produce a single event.

Test Plan (N_IO=8, STEP_DIV=10, DB_CYCLES=4):
1. Release reset, keys high → o_io=0x00 for 1 cycle, then 0xAA; after first o_step 0x55, next 0xAA. o_step period 10 cycles. o_led=4'b0100, then bit3 toggles per tick.
2. key0 low 20 cycles → single press pulse at edge 7; mode=1, o_io=0x01. Steps give 0x02, 0x04 … 0x80, then wrap to 0x01.
3. key0 low 3 cycles then high → no event, mode stays 0, pattern unaffected.
4. key1 press → run=0, o_led[2]=0, o_io frozen across 5 ticks. Each key2 press advances exactly once (WALK 0x01→0x02). A second key1 press resumes on ticks.
5. Mode 2 (two key0 presses), freeze, step to 0xFF, key2 → 0x00. key3 press with state 0x37 → 0x00, mode unchanged.
6. Mode 2, state 0x37, assert i_rst 1 cycle coincident with a tick and a key0 event → next edge: all outputs 0, mode 0. After release, o_io=0xAA and the first o_step is 10 edges later.
